// File: rtl/turn_power_ctrl.sv
// N-player round-robin turn controller with ping-pong throw power meter.
// Grants turns, charges power while the key is held, and tracks the winner.
module turn_power_ctrl #(
   parameter int N_PLAYERS      = 2,
   parameter int POWER_W        = 8,
   parameter int POWER_MIN      = 16,
   parameter int POWER_STEP     = 4,
   parameter int TIMEOUT_FRAMES = 600
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         frame_tick,
   input  logic                         throw_trigger,
   input  logic [N_PLAYERS-1:0]         throw_complete,
   input  logic [N_PLAYERS-1:0]         player_alive,
   output logic [N_PLAYERS-1:0]         turn_onehot,
   output logic [$clog2(N_PLAYERS)-1:0] turn_idx,
   output logic                         charging,
   output logic [POWER_W-1:0]           power_out,
   output logic                         throw_command,
   output logic                         turn_timeout,
   output logic                         game_over,
   output logic [N_PLAYERS-1:0]         winner
);

   localparam int IDX_W = $clog2(N_PLAYERS);
   localparam int CNT_W = (TIMEOUT_FRAMES > 0) ?
                          $clog2(TIMEOUT_FRAMES + 1) : 1;
   localparam int PMAX  = (1 << POWER_W) - 1;

   localparam logic [POWER_W:0]   MAX_X  = (POWER_W+1)'(PMAX);
   localparam logic [POWER_W:0]   MIN_X  = (POWER_W+1)'(POWER_MIN);
   localparam logic [POWER_W:0]   STEP_X = (POWER_W+1)'(POWER_STEP);
   localparam logic [POWER_W-1:0] MAX_W  = POWER_W'(PMAX);
   localparam logic [POWER_W-1:0] MIN_W  = POWER_W'(POWER_MIN);
   localparam logic [POWER_W-1:0] STEP_W = POWER_W'(POWER_STEP);
   localparam logic [CNT_W-1:0]   TO_C   = CNT_W'(TIMEOUT_FRAMES);
   localparam logic [N_PLAYERS-1:0] ONE  = N_PLAYERS'(1);

   typedef enum logic [2:0] {
      S_WAIT_RELEASE,
      S_AIM,
      S_CHARGE,
      S_FLIGHT,
      S_ADVANCE,
      S_GAME_OVER
   } state_t;

   state_t             state;
   logic [POWER_W-1:0] meter;
   logic               dir_up;
   logic [CNT_W-1:0]   frame_cnt;

   logic [POWER_W:0]   meter_x;
   logic [POWER_W:0]   up_sum;
   logic [POWER_W-1:0] meter_nxt;
   logic               dir_nxt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               timeout_hit;
   logic               cur_alive;
   logic               cur_done;
   logic               few_alive;
   logic [IDX_W-1:0]   next_idx;
   logic [IDX_W-1:0]   cand;
   logic               found;

   assign meter_x     = {1'b0, meter};
   assign up_sum      = meter_x + STEP_X;
   assign cnt_inc     = frame_cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT_FRAMES != 0) && frame_tick &&
                        (cnt_inc == TO_C);
   assign cur_alive   = player_alive[turn_idx];
   assign cur_done    = throw_complete[turn_idx];
   assign few_alive   = ($countones(player_alive) <= 1);

   // Ping-pong meter step: saturate at either bound and reverse there
   always_comb begin
      meter_nxt = meter;
      dir_nxt   = dir_up;
      if (dir_up) begin
         if (up_sum >= MAX_X) begin
            meter_nxt = MAX_W;
            dir_nxt   = 1'b0;
         end else begin
            meter_nxt = up_sum[POWER_W-1:0];
         end
      end else begin
         if (meter_x <= MIN_X + STEP_X) begin
            meter_nxt = MIN_W;
            dir_nxt   = 1'b1;
         end else begin
            meter_nxt = meter - STEP_W;
         end
      end
   end

   // First living player after the current one, wrapping around
   always_comb begin
      next_idx = turn_idx;
      cand     = '0;
      found    = 1'b0;
      for (int k = 1; k < N_PLAYERS; k++) begin
         cand = IDX_W'((int'(turn_idx) + k) % N_PLAYERS);
         if (!found && player_alive[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   // Turn FSM with registered outputs, meter and frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_WAIT_RELEASE;
         turn_idx      <= '0;
         turn_onehot   <= ONE;
         power_out     <= '0;
         meter         <= '0;
         dir_up        <= 1'b0;
         frame_cnt     <= '0;
         charging      <= 1'b0;
         throw_command <= 1'b0;
         turn_timeout  <= 1'b0;
         game_over     <= 1'b0;
         winner        <= '0;
      end else begin
         throw_command <= 1'b0;
         turn_timeout  <= 1'b0;
         unique case (state)
            S_WAIT_RELEASE: begin
               if (!throw_trigger) state <= S_AIM;
            end
            S_AIM: begin
               if (frame_tick) frame_cnt <= cnt_inc;
               if (throw_trigger) begin
                  state     <= S_CHARGE;
                  meter     <= MIN_W;
                  power_out <= MIN_W;
                  dir_up    <= 1'b1;
                  charging  <= 1'b1;
               end else if (timeout_hit) begin
                  turn_timeout <= 1'b1;
                  state        <= S_ADVANCE;
               end else if (!cur_alive) begin
                  state <= S_ADVANCE;
               end
            end
            S_CHARGE: begin
               if (!throw_trigger) begin
                  power_out     <= meter;
                  throw_command <= 1'b1;
                  charging      <= 1'b0;
                  state         <= S_FLIGHT;
               end else if (frame_tick) begin
                  meter     <= meter_nxt;
                  power_out <= meter_nxt;
                  dir_up    <= dir_nxt;
               end
            end
            S_FLIGHT: begin
               if (cur_done) state <= S_ADVANCE;
            end
            S_ADVANCE: begin
               frame_cnt <= '0;
               if (few_alive) begin
                  winner      <= player_alive;
                  game_over   <= 1'b1;
                  turn_onehot <= '0;
                  state       <= S_GAME_OVER;
               end else begin
                  turn_idx    <= next_idx;
                  turn_onehot <= ONE << next_idx;
                  state       <= S_WAIT_RELEASE;
               end
            end
            S_GAME_OVER: begin
            end
            default: state <= S_WAIT_RELEASE;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_power_ctrl.sv
// Randomized turn/throw scenarios for turn_power_ctrl (N=4, timeout 5)
// checked against a turn-level reference model.
module tb_turn_power_ctrl;

   localparam int N    = 4;
   localparam int PW   = 8;
   localparam int PMIN = 16;
   localparam int STEP = 4;
   localparam int TO   = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_tick = 1'b0;
   logic          throw_trigger = 1'b0;
   logic [N-1:0]  throw_complete = '0;
   logic [N-1:0]  player_alive = '1;
   logic [N-1:0]  turn_onehot;
   logic [1:0]    turn_idx;
   logic          charging;
   logic [PW-1:0] power_out;
   logic          throw_command;
   logic          turn_timeout;
   logic          game_over;
   logic [N-1:0]  winner;

   int n_chk = 0;
   int n_err = 0;
   int cur = 0;
   int last_pow = 0;
   bit over = 1'b0;

   turn_power_ctrl #(
      .N_PLAYERS(N), .POWER_W(PW), .POWER_MIN(PMIN),
      .POWER_STEP(STEP), .TIMEOUT_FRAMES(TO)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
      .throw_trigger(throw_trigger), .throw_complete(throw_complete),
      .player_alive(player_alive), .turn_onehot(turn_onehot),
      .turn_idx(turn_idx), .charging(charging), .power_out(power_out),
      .throw_command(throw_command), .turn_timeout(turn_timeout),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: sim time expired, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Meter value after k frame steps of the bouncing charge
   function automatic int meter_after(int k);
      int v  = PMIN;
      bit up = 1'b1;
      int mx = (1 << PW) - 1;
      for (int i = 0; i < k; i++) begin
         if (up) begin
            v = v + STEP;
            if (v >= mx) begin v = mx; up = 1'b0; end
         end else begin
            v = v - STEP;
            if (v <= PMIN) begin v = PMIN; up = 1'b1; end
         end
      end
      return v;
   endfunction

   function automatic int next_alive(int c, logic [N-1:0] a);
      for (int k = 1; k < N; k++)
         if (a[(c + k) % N]) return (c + k) % N;
      return c;
   endfunction

   function automatic int live_count(logic [N-1:0] a);
      int n = 0;
      for (int i = 0; i < N; i++) n += int'(a[i]);
      return n;
   endfunction

   // One full turn; mode 0 = press and throw, 1 = let it time out
   task automatic do_turn(input int mode, input int kfr, input bit hold,
                          input logic [N-1:0] flight_alive);
      check("turn_onehot", 32'(turn_onehot), 32'(1) << cur);
      check("turn_idx", 32'(turn_idx), cur);
      check("power_held", 32'(power_out), last_pow);
      if (throw_trigger) begin
         repeat (3) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("held_no_charge", 32'(charging), 0);
            check("held_power", 32'(power_out), last_pow);
         end
         throw_trigger = 1'b0;
      end
      step();
      if (!player_alive[cur]) begin
         step();
         check("dead_no_timeout", 32'(turn_timeout), 0);
         step();
      end else if (mode == 0) begin
         repeat ($urandom_range(0, 3)) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
         end
         throw_trigger = 1'b1;
         step();
         check("charge_on", 32'(charging), 1);
         check("charge_start", 32'(power_out), PMIN);
         for (int j = 1; j <= kfr; j++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("meter", 32'(power_out), meter_after(j));
            repeat ($urandom_range(0, 2)) step();
         end
         throw_trigger = 1'b0;
         frame_tick = 1'($urandom_range(0, 1));
         step();
         frame_tick = 1'b0;
         check("throw_cmd", 32'(throw_command), 1);
         check("throw_power", 32'(power_out), meter_after(kfr));
         check("charge_off", 32'(charging), 0);
         last_pow = meter_after(kfr);
         step();
         check("throw_cmd_once", 32'(throw_command), 0);
         if (hold) throw_trigger = 1'b1;
         player_alive = flight_alive;
         repeat ($urandom_range(0, 3)) begin
            throw_complete = N'($urandom) & ~(N'(1) << cur);
            frame_tick = 1'($urandom_range(0, 1));
            step();
            check("flight_hold", 32'(turn_onehot), 32'(1) << cur);
         end
         frame_tick = 1'b0;
         throw_complete = N'(1) << cur;
         step();
         throw_complete = '0;
         step();
      end else begin
         for (int t = 1; t <= TO; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            check("timeout_pulse", 32'(turn_timeout), 32'(t == TO));
            if (t < TO) repeat ($urandom_range(0, 2)) step();
         end
         check("timeout_no_throw", 32'(throw_command), 0);
         step();
         check("timeout_once", 32'(turn_timeout), 0);
      end
      if (live_count(player_alive) <= 1) begin
         check("game_over", 32'(game_over), 1);
         check("winner", 32'(winner), 32'(player_alive));
         check("over_onehot", 32'(turn_onehot), 0);
         over = 1'b1;
      end else begin
         check("no_game_over", 32'(game_over), 0);
         cur = next_alive(cur, player_alive);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_onehot", 32'(turn_onehot), 1);
      check("rst_idx", 32'(turn_idx), 0);
      check("rst_power", 32'(power_out), 0);
      check("rst_charging", 32'(charging), 0);
      check("rst_throw", 32'(throw_command), 0);
      check("rst_timeout", 32'(turn_timeout), 0);
      check("rst_game_over", 32'(game_over), 0);
      check("rst_winner", 32'(winner), 0);
      rst_n = 1'b1;

      do_turn(0, 10, 1'b0, 4'b1111);
      check("plan_56", 32'(power_out), 56);
      do_turn(0, 70, 1'b1, 4'b1111);
      check("plan_215", 32'(power_out), 215);
      do_turn(1, 0, 1'b0, 4'b1111);
      for (int i = 0; i < 10; i++)
         do_turn(int'($urandom_range(0, 1)), int'($urandom_range(0, 130)),
                 1'($urandom_range(0, 1)), 4'b1111);

      player_alive = 4'b1011;
      for (int i = 0; i < 8 && !over; i++)
         do_turn(0, int'($urandom_range(0, 20)), 1'b0,
                 (cur == 3) ? 4'b0001 : 4'b1011);
      check("reached_game_over", 32'(over), 1);

      for (int i = 0; i < 12; i++) begin
         throw_trigger  = 1'($urandom_range(0, 1));
         frame_tick     = 1'($urandom_range(0, 1));
         throw_complete = N'($urandom);
         player_alive   = N'($urandom);
         step();
         check("absorb_over", 32'(game_over), 1);
         check("absorb_winner", 32'(winner), 32'(4'b0001));
         check("absorb_throw", 32'(throw_command) | 32'(charging), 0);
      end

      rst_n = 1'b0;
      throw_trigger = 1'b0;
      frame_tick = 1'b0;
      throw_complete = '0;
      player_alive = 4'b1111;
      step();
      rst_n = 1'b1;
      cur = 0;
      last_pow = 0;
      step();
      throw_trigger = 1'b1;
      step();
      repeat (3) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
      end
      check("pre_reset_power", 32'(power_out), meter_after(3));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_charging", 32'(charging), 0);
      check("async_power", 32'(power_out), 0);
      check("async_throw", 32'(throw_command), 0);
      check("async_onehot", 32'(turn_onehot), 1);
      throw_trigger = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      repeat (5) begin
         step();
         check("no_throw_after_rst", 32'(throw_command), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
